ni_packetizer: RTL and testbench

- Network-interface injection block: the source end of the destination-routing protocol that the router's routing computation consumes.
- Accepts packet descriptors (8-bit dst, length) and a payload stream, builds a head flit carrying dst in its low byte, and serialises head/body/tail flits into a router local input port.
- Selects a downstream VC per packet, holds it for the whole packet (wormhole), and tracks per-VC downstream buffer credits.

---
 rtl/ni_packetizer_pkg.sv | 41 ++++
 rtl/ni_packetizer_vc_credit_counter.sv | 39 +++
 rtl/ni_packetizer.sv | 149 ++++++++++++++
 tb/tb_ni_packetizer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ni_packetizer_pkg.sv
// Shared constants for the NI packetizer: VC count, flit type codes, head-flit field layout.
package ni_packetizer_pkg;

    localparam int NUM_VC   = 4;
    localparam int VC_IDX_W = $clog2(NUM_VC);

    localparam logic [1:0] FT_HEAD   = 2'b00;
    localparam logic [1:0] FT_BODY   = 2'b01;
    localparam logic [1:0] FT_TAIL   = 2'b10;
    localparam logic [1:0] FT_SINGLE = 2'b11;

    localparam int HF_DST_LSB     = 0;
    localparam int HF_Y_LSB       = 8;
    localparam int HF_X_LSB       = 12;
    localparam int HF_LEN_LSB     = 16;
    localparam int HEAD_PAYLOAD_W = 24;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HEAD = 2'd1;
    localparam logic [1:0] ST_BODY = 2'd2;

    function automatic logic [HEAD_PAYLOAD_W-1:0] head_payload(
        input logic [7:0] dst,
        input logic [3:0] x,
        input logic [3:0] y,
        input logic [7:0] len
    );
        logic [HEAD_PAYLOAD_W-1:0] p;
        p = '0;
        p[HF_DST_LSB +: 8] = dst;
        p[HF_Y_LSB   +: 4] = y;
        p[HF_X_LSB   +: 4] = x;
        p[HF_LEN_LSB +: 8] = len;
        return p;
    endfunction

    function automatic logic [NUM_VC-1:0] vc_onehot(input logic [VC_IDX_W-1:0] idx);
        return NUM_VC'(1) << idx;
    endfunction

endpackage

// File: rtl/ni_packetizer_vc_credit_counter.sv
// Per-VC downstream credit counter: starts full, +1 on credit return, -1 on send.
module vc_credit_counter #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o,
    output logic          nonzero_o
);

    localparam logic [CW-1:0] MAX_CNT = CW'(DEPTH);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i) begin
            if (count_q != MAX_CNT) count_d = count_q + CW'(1);
        end else if (dec_i && !inc_i) begin
            if (count_q != '0) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= MAX_CNT;
        else     count_q <= count_d;
    end

    assign count_o   = count_q;
    assign nonzero_o = (count_q != '0);

    // A credit returned into a full counter means the downstream buffer lied.
    credit_overflow_a: assert property (@(posedge clk) disable iff (rst)
        !(inc_i && !dec_i && (count_q == MAX_CNT)));

endmodule

// File: rtl/ni_packetizer.sv
// NI injection: turns descriptors plus payload into head/body/tail flits on a per-packet VC.
module ni_packetizer
    import ni_packetizer_pkg::*;
#(
    parameter int CUR_X     = 0,
    parameter int CUR_Y     = 0,
    parameter int FLIT_W    = 32,
    parameter int BUF_DEPTH = 4,
    localparam int CW       = $clog2(BUF_DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pkt_valid,
    output logic                         pkt_ready,
    input  logic [7:0]                   pkt_dst,
    input  logic [7:0]                   pkt_len,
    input  logic                         data_valid,
    output logic                         data_ready,
    input  logic [FLIT_W-3:0]            data_in,
    output logic                         flit_valid,
    output logic [FLIT_W-1:0]            flit_out,
    output logic [NUM_VC-1:0]            flit_vc,
    input  logic [NUM_VC-1:0]            credit_in,
    output logic [1:0]                   dbg_state,
    output logic [NUM_VC-1:0][CW-1:0]    dbg_credits
);

    logic [1:0]              state_q, state_d;
    logic [7:0]              rem_q, rem_d;
    logic [7:0]              dst_q, len_q;
    logic [VC_IDX_W-1:0]     vc_q, rr_q;
    logic                    flit_valid_q;
    logic [FLIT_W-1:0]       flit_q;
    logic [NUM_VC-1:0]       flit_vc_q;

    logic [NUM_VC-1:0][CW-1:0] credit_cnt;
    logic [NUM_VC-1:0]       credit_nz;
    logic [NUM_VC-1:0]       credit_dec;
    logic                    sel_found;
    logic [VC_IDX_W-1:0]     sel_idx, cand;
    logic                    head_fire, body_fire;
    logic [FLIT_W-1:0]       head_flit;

    // Round-robin search from rr_q; NUM_VC is a power of two so the index wraps naturally.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = rr_q;
        cand      = rr_q;
        for (int i = 0; i < NUM_VC; i++) begin
            cand = rr_q + VC_IDX_W'(i);
            if (!sel_found && credit_nz[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign pkt_ready  = !rst && (state_q == ST_IDLE);
    assign data_ready = !rst && (state_q == ST_BODY) && credit_nz[vc_q];
    assign head_fire  = (state_q == ST_HEAD) && sel_found;
    assign body_fire  = data_valid && data_ready;

    always_comb begin
        head_flit = '0;
        head_flit[FLIT_W-1 -: 2] = (len_q == 8'd0) ? FT_SINGLE : FT_HEAD;
        head_flit[HEAD_PAYLOAD_W-1:0] = head_payload(dst_q, 4'(CUR_X), 4'(CUR_Y), len_q);
    end

    always_comb begin
        credit_dec = '0;
        if (head_fire) credit_dec[sel_idx] = 1'b1;
        if (body_fire) credit_dec[vc_q]    = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (pkt_valid) begin
                    state_d = ST_HEAD;
                    rem_d   = pkt_len;
                end
            end
            ST_HEAD: begin
                if (sel_found) state_d = (len_q == 8'd0) ? ST_IDLE : ST_BODY;
            end
            ST_BODY: begin
                if (body_fire) begin
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rem_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            vc_q         <= '0;
            rr_q         <= '0;
            flit_valid_q <= 1'b0;
            flit_q       <= '0;
            flit_vc_q    <= '0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            flit_valid_q <= head_fire || body_fire;
            if (state_q == ST_IDLE && pkt_valid) begin
                dst_q <= pkt_dst;
                len_q <= pkt_len;
            end
            if (head_fire) begin
                flit_q    <= head_flit;
                flit_vc_q <= vc_onehot(sel_idx);
                vc_q      <= sel_idx;
                rr_q      <= sel_idx + VC_IDX_W'(1);
            end else if (body_fire) begin
                flit_q    <= {(rem_q == 8'd1) ? FT_TAIL : FT_BODY, data_in};
                flit_vc_q <= vc_onehot(vc_q);
            end
        end
    end

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        vc_credit_counter #(
            .DEPTH (BUF_DEPTH),
            .CW    (CW)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc_i     (credit_in[v]),
            .dec_i     (credit_dec[v]),
            .count_o   (credit_cnt[v]),
            .nonzero_o (credit_nz[v])
        );
    end

    assign flit_valid  = flit_valid_q;
    assign flit_out    = flit_q;
    assign flit_vc     = flit_vc_q;
    assign dbg_state   = state_q;
    assign dbg_credits = credit_cnt;

endmodule

// File: tb/tb_ni_packetizer.sv
// Directed bench for ni_packetizer: flit scoreboard, RR/credit stalls, same-cycle credit, mid-packet reset.
module tb_ni_packetizer;

    localparam int FW = 32;
    localparam int BD = 4;

    logic             clk;
    logic             rst;
    logic             pkt_valid;
    logic             pkt_ready;
    logic [7:0]       pkt_dst;
    logic [7:0]       pkt_len;
    logic             data_valid;
    logic             data_ready;
    logic [FW-3:0]    data_in;
    logic             flit_valid;
    logic [FW-1:0]    flit_out;
    logic [3:0]       flit_vc;
    logic [3:0]       credit_in;
    logic [1:0]       dbg_state;
    logic [3:0][2:0]  dbg_credits;

    int n_total = 0;
    int n_bad   = 0;
    int n_obs   = 0;
    int cyc     = 0;
    int acc_cyc = 0;
    logic [35:0] exp_q[$];
    int          obs_cyc[$];
    logic [35:0] e;

    ni_packetizer #(
        .CUR_X     (3),
        .CUR_Y     (5),
        .FLIT_W    (FW),
        .BUF_DEPTH (BD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .pkt_dst     (pkt_dst),
        .pkt_len     (pkt_len),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .data_in     (data_in),
        .flit_valid  (flit_valid),
        .flit_out    (flit_out),
        .flit_vc     (flit_vc),
        .credit_in   (credit_in),
        .dbg_state   (dbg_state),
        .dbg_credits (dbg_credits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] head_flit(input logic [7:0] dst, input logic [7:0] len);
        logic [1:0] t;
        t = (len == 8'd0) ? 2'b11 : 2'b00;
        return {t, 6'b0, len, 4'h3, 4'h5, dst};
    endfunction

    function automatic logic [29:0] pay(input logic [7:0] tag, input int i);
        return {2'b10, tag, 12'h0, 8'(i)};
    endfunction

    function automatic logic [31:0] body_flit(input logic last, input logic [29:0] p);
        return {last ? 2'b10 : 2'b01, p};
    endfunction

    // Scoreboard: every flit on the wire must match the head of exp_q.
    always @(negedge clk) begin
        if (flit_valid === 1'b1) begin
            n_obs++;
            obs_cyc.push_back(cyc);
            check("flit_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("flit", {28'h0, flit_vc, flit_out}, {28'h0, e});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick;
            k++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic send_payload(input logic [29:0] d);
        int k;
        data_valid = 1'b1;
        data_in    = d;
        k = 0;
        while (!data_ready && k < 20) begin
            tick;
            k++;
        end
        check("data_ready_wait", 64'(k < 20), 64'd1);
        tick;
    endtask

    task automatic start_pkt(input logic [7:0] dst, input logic [7:0] len);
        int k;
        k = 0;
        while (!pkt_ready && k < 20) begin
            tick;
            k++;
        end
        check("pkt_ready", 64'(pkt_ready), 64'd1);
        pkt_valid = 1'b1;
        pkt_dst   = dst;
        pkt_len   = len;
        tick;
        acc_cyc   = cyc;
        pkt_valid = 1'b0;
    endtask

    task automatic run_pkt(input logic [7:0] dst, input logic [7:0] len,
                           input logic [7:0] tag, input logic [3:0] vc);
        exp_q.push_back({vc, head_flit(dst, len)});
        for (int i = 0; i < int'(len); i++)
            exp_q.push_back({vc, body_flit(i == int'(len) - 1, pay(tag, i))});
        start_pkt(dst, len);
        for (int i = 0; i < int'(len); i++) send_payload(pay(tag, i));
        data_valid = 1'b0;
        drain(20);
    endtask

    task automatic pulse_credit(input logic [3:0] mask, input int n);
        for (int i = 0; i < n; i++) begin
            credit_in = mask;
            tick;
        end
        credit_in = 4'b0;
    endtask

    initial begin
        int n_start;
        logic [3:0] order [4];
        order = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};

        rst = 1'b1; pkt_valid = 1'b0; pkt_dst = '0; pkt_len = '0;
        data_valid = 1'b0; data_in = '0; credit_in = '0;
        tick;
        tick;
        check("rst_flit_valid", 64'(flit_valid), 64'd0);
        check("rst_flit_out", 64'(flit_out), 64'd0);
        check("rst_flit_vc", 64'(flit_vc), 64'd0);
        check("rst_data_ready", 64'(data_ready), 64'd0);
        check("rst_pkt_ready", 64'(pkt_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_pkt_ready", 64'(pkt_ready), 64'd1);
        check("post_rst_state", 64'(dbg_state), 64'd0);
        for (int v = 0; v < 4; v++) check("post_rst_credit", 64'(dbg_credits[v]), 64'(BD));

        // dst=23, len=2 on VC0, back-to-back flits
        obs_cyc.delete();
        run_pkt(8'h23, 8'd2, 8'hA1, 4'b0001);
        check("t1_nflits", 64'(obs_cyc.size()), 64'd3);
        check("t1_head_latency", 64'(obs_cyc[0] - acc_cyc), 64'd1);
        check("t1_body_gap", 64'(obs_cyc[1] - obs_cyc[0]), 64'd1);
        check("t1_tail_gap", 64'(obs_cyc[2] - obs_cyc[1]), 64'd1);
        check("t1_vc0_credit", 64'(dbg_credits[0]), 64'(BD - 3));

        // len=0: single head+tail flit, round-robins to VC1
        run_pkt(8'h45, 8'd0, 8'hB2, 4'b0010);
        check("t2_state_idle", 64'(dbg_state), 64'd0);
        check("t2_vc1_credit", 64'(dbg_credits[1]), 64'(BD - 1));
        pulse_credit(4'b0011, 1);
        pulse_credit(4'b0001, 2);
        check("t2_vc0_refill", 64'(dbg_credits[0]), 64'(BD));
        check("t2_vc1_refill", 64'(dbg_credits[1]), 64'(BD));

        // len=6 on VC2 with only BD credits: stall, one-flit-per-credit, same-cycle inc/dec
        n_start = n_obs;
        exp_q.push_back({4'b0100, head_flit(8'h31, 8'd6)});
        for (int i = 0; i < 6; i++) exp_q.push_back({4'b0100, body_flit(i == 5, pay(8'hC3, i))});
        start_pkt(8'h31, 8'd6);
        for (int i = 0; i < 3; i++) send_payload(pay(8'hC3, i));
        data_in = pay(8'hC3, 3);
        check("t3_ready_stalled", 64'(data_ready), 64'd0);
        tick;
        tick;
        check("t3_stall_state", 64'(dbg_state), 64'd2);
        check("t3_flits_before_credit", 64'(n_obs - n_start), 64'd4);
        credit_in = 4'b0100;
        tick;
        credit_in = 4'b0;
        check("t3_ready_after_credit", 64'(data_ready), 64'd1);
        tick;
        data_in = pay(8'hC3, 4);
        check("t3_ready_after_one", 64'(data_ready), 64'd0);
        tick;
        tick;
        check("t3_one_more_flit", 64'(n_obs - n_start), 64'd5);
        credit_in = 4'b0100;
        tick;
        tick;
        credit_in = 4'b0;
        check("t3_same_cycle_inc_dec", 64'(dbg_credits[2]), 64'd1);
        data_in = pay(8'hC3, 5);
        tick;
        data_valid = 1'b0;
        drain(20);
        check("t3_done_state", 64'(dbg_state), 64'd0);
        check("t3_vc2_empty", 64'(dbg_credits[2]), 64'd0);
        check("t3_total_flits", 64'(n_obs - n_start), 64'd7);
        pulse_credit(4'b0100, 4);

        // Drain every VC to zero credits, then stall a head until VC2 alone gets a credit
        for (int p = 0; p < 4; p++) run_pkt(8'h60 + 8'(p), 8'd3, 8'hD0 + 8'(p), order[p]);
        for (int v = 0; v < 4; v++) check("t4_credit_zero", 64'(dbg_credits[v]), 64'd0);
        exp_q.push_back({4'b0100, head_flit(8'h77, 8'd0)});
        start_pkt(8'h77, 8'd0);
        n_start = n_obs;
        repeat (4) tick;
        check("t4_no_flit_stalled", 64'(n_obs - n_start), 64'd0);
        check("t4_stall_in_head", 64'(dbg_state), 64'd1);
        check("t4_pkt_ready_low", 64'(pkt_ready), 64'd0);
        pulse_credit(4'b0100, 1);
        drain(10);
        check("t4_vc2_used", 64'(dbg_credits[2]), 64'd0);

        // Reset in the middle of a packet on VC3
        pulse_credit(4'b1111, 4);
        exp_q.push_back({4'b1000, head_flit(8'h5A, 8'd5)});
        exp_q.push_back({4'b1000, body_flit(1'b0, pay(8'hE5, 0))});
        exp_q.push_back({4'b1000, body_flit(1'b0, pay(8'hE5, 1))});
        start_pkt(8'h5A, 8'd5);
        send_payload(pay(8'hE5, 0));
        send_payload(pay(8'hE5, 1));
        rst        = 1'b1;
        data_valid = 1'b0;
        tick;
        check("mid_rst_flit_valid", 64'(flit_valid), 64'd0);
        check("mid_rst_flit_out", 64'(flit_out), 64'd0);
        check("mid_rst_flit_vc", 64'(flit_vc), 64'd0);
        check("mid_rst_data_ready", 64'(data_ready), 64'd0);
        check("mid_rst_state", 64'(dbg_state), 64'd0);
        for (int v = 0; v < 4; v++) check("mid_rst_credit", 64'(dbg_credits[v]), 64'(BD));
        check("mid_rst_scoreboard", 64'(exp_q.size()), 64'd0);
        rst = 1'b0;
        #1;
        check("after_rst_pkt_ready", 64'(pkt_ready), 64'd1);
        run_pkt(8'h12, 8'd1, 8'hF6, 4'b0001);
        repeat (3) tick;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
